// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the memory-mapped UART transmitter.
//   - register offsets inside the 8-byte window
//   - STATUS bit positions
//   - serializer FSM state encoding
package uart_pkg;

    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_STATUS = 3'd4;

    localparam int ST_BUSY = 0;
    localparam int ST_FULL = 1;
    localparam int ST_OVF  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_mmio_fifo.sv
// tx_fifo: 8-bit wide, 4-deep FIFO feeding the UART serializer.
// Ports:
//   clkd, RESET   - clock, synchronous active-low reset
//   push_i, din_i - write strobe and byte (ignored while full)
//   pop_i, dout_o - read strobe (ignored while empty); dout_o shows the head
//   full_o, empty_o - occupancy flags
module tx_fifo (
    input  logic       clkd,
    input  logic       RESET,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic [7:0] dout_o,
    output logic       full_o,
    output logic       empty_o
);

    logic [7:0] mem_q [4];
    logic [1:0] wptr_q, wptr_d;
    logic [1:0] rptr_q, rptr_d;
    logic [2:0] cnt_q,  cnt_d;
    logic       do_push, do_pop;

    assign full_o  = (cnt_q == 3'd4);
    assign empty_o = (cnt_q == 3'd0);
    assign dout_o  = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = wptr_q + 2'd1;   // wraps 3 -> 0
        if (do_pop)  rptr_d = rptr_q + 2'd1;
        // push and pop together leave the count untouched
        if (do_push && !do_pop)      cnt_d = cnt_q + 3'd1;
        else if (do_pop && !do_push) cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clkd) begin
        if (!RESET) begin
            wptr_q <= 2'd0;
            rptr_q <= 2'd0;
            cnt_q  <= 3'd0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // storage needs no reset: the count gates every read
    always_ff @(posedge clkd) begin
        if (do_push) mem_q[wptr_q] <= din_i;
    end

endmodule

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter (LSB first).
// Ports:
//   clkd, RESET          - clock, synchronous active-low reset
//   mem_addr/wdata/wmask - CPU store path; DATA write pushes wdata[7:0]
//   mem_rstrb, mem_rdata - CPU load strobe and registered read data
//   TXD                  - serial line, idles high
//   irq_empty            - FIFO empty and serializer idle
module uart_tx_mmio
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 4,
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
    input  logic        clkd,
    input  logic        RESET,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        TXD,
    output logic        irq_empty
);

    localparam int             TW    = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  TLOAD = TW'(CLKS_PER_BIT - 1);

    tx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          txd_q, txd_d;
    logic          ovf_q, ovf_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [31:0]   status_w;

    logic       sel, is_status, wr_data, rd_status, pop;
    logic       full, empty;
    logic [7:0] fifo_dout;

    logic unused_bits;
    assign unused_bits = ^{mem_addr[1:0], mem_wdata[31:8], mem_wmask[3:1]};

    assign sel       = (mem_addr[31:3] == BASE_ADDR[31:3]);
    assign is_status = (mem_addr[2] == REG_STATUS[2]);
    assign wr_data   = sel && mem_wmask[0] && !is_status;
    assign rd_status = sel && mem_rstrb && is_status;

    tx_fifo u_fifo (
        .clkd    (clkd),
        .RESET   (RESET),
        .push_i  (wr_data),
        .pop_i   (pop),
        .din_i   (mem_wdata[7:0]),
        .dout_o  (fifo_dout),
        .full_o  (full),
        .empty_o (empty)
    );

    always_comb begin
        status_w          = 32'h0;
        status_w[ST_BUSY] = (state_q != IDLE) || !empty;
        status_w[ST_FULL] = full;
        status_w[ST_OVF]  = ovf_q;
    end

    // a dropped write in the same cycle as a STATUS read keeps the flag set
    always_comb begin
        ovf_d   = ovf_q;
        rdata_d = rdata_q;
        if (wr_data && full) ovf_d = 1'b1;
        else if (rd_status)  ovf_d = 1'b0;
        if (sel && mem_rstrb) rdata_d = is_status ? status_w : 32'h0;
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        timer_d  = timer_q;
        txd_d    = txd_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_dout;
                    txd_d   = 1'b0;
                    timer_d = TLOAD;
                    state_d = START;
                end
            end
            START: begin
                if (timer_q == '0) begin
                    state_d  = DATA;
                    txd_d    = shift_q[0];
                    timer_d  = TLOAD;
                    bitcnt_d = 3'd0;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            DATA: begin
                if (timer_q == '0) begin
                    timer_d = TLOAD;
                    if (bitcnt_q == 3'd7) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        // next bit is shift[1] before the shift lands
                        shift_d  = {1'b0, shift_q[7:1]};
                        txd_d    = shift_q[1];
                        bitcnt_d = bitcnt_q + 3'd1;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            STOP: begin
                if (timer_q == '0) begin
                    if (!empty) begin
                        // chain straight into the next start bit
                        pop     = 1'b1;
                        shift_d = fifo_dout;
                        txd_d   = 1'b0;
                        timer_d = TLOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkd) begin
        if (!RESET) begin
            state_q  <= IDLE;
            shift_q  <= 8'h0;
            bitcnt_q <= 3'd0;
            timer_q  <= '0;
            txd_q    <= 1'b1;
            ovf_q    <= 1'b0;
            rdata_q  <= 32'h0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            timer_q  <= timer_d;
            txd_q    <= txd_d;
            ovf_q    <= ovf_d;
            rdata_q  <= rdata_d;
        end
    end

    assign TXD       = txd_q;
    assign mem_rdata = rdata_q;
    assign irq_empty = (state_q == IDLE) && empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: bytes accepted by the CPU model go into exp_q; a
// line monitor decodes every frame cycle by cycle and checks it against the
// queue head.
module tb_uart_tx_mmio;
    import uart_pkg::*;

    localparam int          CPB  = 4;
    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clkd      = 1'b0;
    logic        RESET     = 1'b0;
    logic [31:0] mem_addr  = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [3:0]  mem_wmask = 4'h0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic        TXD;
    logic        irq_empty;

    always #5 clkd = ~clkd;

    uart_tx_mmio #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
        .clkd      (clkd),
        .RESET     (RESET),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .TXD       (TXD),
        .irq_empty (irq_empty)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    // line monitor
    int         mon_cyc = -1;
    int         gap = 0;
    int         last_gap = 0;
    int         frames_rx = 0;
    logic [9:0] mon_bits;
    logic       mon_glitch;
    logic [7:0] mon_exp;
    int         mb, mc;

    always @(negedge clkd) begin
        if (!RESET) begin
            mon_cyc = -1;
            gap     = 0;
        end else begin
            if (mon_cyc < 0 && TXD === 1'b0) begin
                mon_cyc    = 0;
                last_gap   = gap;
                gap        = 0;
                mon_glitch = 1'b0;
                mon_bits   = '0;
            end
            if (mon_cyc < 0) begin
                gap++;
            end else begin
                mb = mon_cyc / CPB;
                mc = mon_cyc % CPB;
                if (mc == 0) mon_bits[mb] = TXD;
                else if (TXD !== mon_bits[mb]) mon_glitch = 1'b1;
                mon_cyc++;
                if (mon_cyc == 10 * CPB) begin
                    mon_cyc = -1;
                    frames_rx++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: got bits %b, required no frame", mon_bits);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        if (mon_bits !== {1'b1, mon_exp, 1'b0} || mon_glitch) begin
                            errors++;
                            $display("FAIL frame: got bits %b glitch %b, required %b glitch 0",
                                     mon_bits, mon_glitch, {1'b1, mon_exp, 1'b0});
                        end
                    end
                end
            end
        end
    end

    task automatic cpu_write(input logic [31:0] a, input logic [7:0] d,
                             input logic [3:0] m, input bit accept);
        @(negedge clkd);
        mem_addr  = a;
        mem_wdata = {24'h0, d};
        mem_wmask = m;
        if (accept) exp_q.push_back(d);
        @(posedge clkd); #1;
        mem_wmask = 4'h0;
    endtask

    task automatic cpu_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge clkd);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        @(posedge clkd); #1;
        mem_rstrb = 1'b0;
        d = mem_rdata;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clkd);
        #1;
    endtask

    task automatic wait_idle(input int bound, output int cyc);
        cyc = 0;
        while (irq_empty !== 1'b1 && cyc < bound) begin
            @(posedge clkd); #1;
            cyc++;
        end
        checks++;
        if (irq_empty !== 1'b1) begin
            errors++;
            $display("FAIL idle_timeout: irq_empty=%b after %0d cycles, required 1", irq_empty, cyc);
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge clkd);
        #1;
        checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b, required 1", TXD); end
        checks++; if (irq_empty !== 1'b1) begin errors++; $display("FAIL reset_irq: got %b, required 1", irq_empty); end
        checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h, required 0", mem_rdata); end
        @(negedge clkd); RESET = 1'b1;
        cpu_read(BASE + 32'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_status: got %h, required 0", d); end
    endtask

    task automatic test_single();
        int f0, cyc;
        f0 = frames_rx;
        cpu_write(BASE, 8'h55, 4'h1, 1'b1);
        checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL single_txd_early: got %b, required 1", TXD); end
        idle(1);
        checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL single_start: got %b, required 0", TXD); end
        wait_idle(100, cyc);
        checks++; if (cyc != 10 * CPB) begin errors++; $display("FAIL single_len: got %0d cycles, required %0d", cyc, 10 * CPB); end
        checks++; if (frames_rx - f0 != 1) begin errors++; $display("FAIL single_frames: got %0d, required 1", frames_rx - f0); end
    endtask

    task automatic test_back_to_back();
        int f0, bad_irq;
        logic [31:0] d;
        f0 = frames_rx;
        bad_irq = 0;
        cpu_write(BASE, 8'h41, 4'h1, 1'b1);
        cpu_write(BASE, 8'h42, 4'h1, 1'b1);
        for (int i = 0; i < 80; i++) begin
            @(negedge clkd);
            mem_addr  = BASE + 32'd4;
            mem_rstrb = (i % 10 == 0);
            @(posedge clkd); #1;
            if (mem_rstrb) begin
                checks++;
                if (mem_rdata[ST_BUSY] !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_busy: cycle %0d got %b, required 1", i, mem_rdata[ST_BUSY]);
                end
            end
            mem_rstrb = 1'b0;
            if (irq_empty !== (i == 79)) bad_irq++;
        end
        checks++; if (bad_irq != 0) begin errors++; $display("FAIL b2b_irq: got %0d wrong cycles, required 0", bad_irq); end
        checks++; if (frames_rx - f0 != 2) begin errors++; $display("FAIL b2b_frames: got %0d, required 2", frames_rx - f0); end
        checks++; if (last_gap != 0) begin errors++; $display("FAIL b2b_gap: got %0d, required 0", last_gap); end
        cpu_read(BASE + 32'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL b2b_status_end: got %h, required 0", d); end
    endtask

    task automatic test_overflow();
        int f0, cyc;
        logic [31:0] d;
        f0 = frames_rx;
        for (int i = 0; i < 6; i++) cpu_write(BASE, 8'(8'h10 + i), 4'h1, i < 5);
        cpu_read(BASE + 32'd4, d);
        checks++; if (d !== 32'h7) begin errors++; $display("FAIL ovf_status1: got %h, required 7", d); end
        cpu_read(BASE + 32'd4, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL ovf_status2: got %h, required 3", d); end
        wait_idle(400, cyc);
        checks++; if (frames_rx - f0 != 5) begin errors++; $display("FAIL ovf_frames: got %0d, required 5", frames_rx - f0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL ovf_queue: got %0d left, required 0", exp_q.size()); end
    endtask

    task automatic test_push_pop();
        int f0, cyc;
        logic [31:0] d;
        f0 = frames_rx;
        cpu_write(BASE, 8'h3C, 4'h1, 1'b1);   // edge N, popped at N+1
        idle(3);
        cpu_write(BASE, 8'h96, 4'h1, 1'b1);   // edge N+4, count 1
        idle(36);
        cpu_write(BASE, 8'hE1, 4'h1, 1'b1);   // edge N+41, same edge as STOP pop
        cpu_write(BASE, 8'h0F, 4'h1, 1'b1);
        cpu_write(BASE, 8'hF0, 4'h1, 1'b1);
        cpu_read(BASE + 32'd4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL pp_status3: got %h, required 1", d); end
        cpu_write(BASE, 8'h5A, 4'h1, 1'b1);
        cpu_read(BASE + 32'd4, d);
        checks++; if (d !== 32'h3) begin errors++; $display("FAIL pp_status4: got %h, required 3", d); end
        wait_idle(600, cyc);
        checks++; if (frames_rx - f0 != 6) begin errors++; $display("FAIL pp_frames: got %0d, required 6", frames_rx - f0); end
        checks++; if (last_gap != 0) begin errors++; $display("FAIL pp_gap: got %0d, required 0", last_gap); end
    endtask

    task automatic test_reset_mid();
        int f0, cyc;
        logic [31:0] d;
        cpu_write(BASE, 8'hC3, 4'h1, 1'b1);
        idle(18);                              // inside data bit 3
        checks++; if (TXD !== 1'b0) begin errors++; $display("FAIL mid_bit3: got %b, required 0", TXD); end
        @(negedge clkd); RESET = 1'b0;
        @(posedge clkd); #1;
        checks++; if (TXD !== 1'b1) begin errors++; $display("FAIL mid_txd: got %b, required 1", TXD); end
        checks++; if (irq_empty !== 1'b1) begin errors++; $display("FAIL mid_irq: got %b, required 1", irq_empty); end
        @(negedge clkd); RESET = 1'b1;
        exp_q.delete();
        f0 = frames_rx;
        cpu_read(BASE + 32'd4, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_status: got %h, required 0", d); end
        cpu_write(BASE, 8'hA5, 4'h1, 1'b1);
        wait_idle(100, cyc);
        checks++; if (frames_rx - f0 != 1) begin errors++; $display("FAIL mid_frames: got %0d, required 1", frames_rx - f0); end
    endtask

    task automatic test_decode();
        int f0, cyc, bad;
        logic [31:0] d;
        cpu_write(BASE, 8'h11, 4'h1, 1'b1);
        cpu_read(BASE + 32'd4, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL dec_busy: got %h, required 1", d); end
        cpu_read(BASE + 32'd12, d);
        checks++; if (d !== 32'h1) begin errors++; $display("FAIL dec_unsel_read: got %h, required 1", d); end
        cpu_read(BASE, d);
        checks++; if (d !== 32'h0) begin errors++; $display("FAIL dec_data_read: got %h, required 0", d); end
        wait_idle(100, cyc);
        f0  = frames_rx;
        bad = 0;
        cpu_write(BASE + 32'd8, 8'h77, 4'h1, 1'b0);
        cpu_write(BASE, 8'h78, 4'b0010, 1'b0);
        for (int i = 0; i < 50; i++) begin
            idle(1);
            if (TXD !== 1'b1 || irq_empty !== 1'b1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL dec_line: got %0d active cycles, required 0", bad); end
        checks++; if (frames_rx != f0) begin errors++; $display("FAIL dec_frames: got %0d, required 0", frames_rx - f0); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_push_pop();
        test_reset_mid();
        test_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

endmodule
